// File: rtl/pc_seq_pkg.sv
// Shared constants and FSM encoding for the next-PC sequencer.
// Build option: define BRANCH_LIKELY_EN to enable delay-slot annulment.
package pc_seq_pkg;

  localparam logic [1:0] MODE_SEQ = 2'd0;
  localparam logic [1:0] MODE_BR  = 2'd1;
  localparam logic [1:0] MODE_J   = 2'd2;
  localparam logic [1:0] MODE_JR  = 2'd3;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-transfer request handshake between decode and the sequencer.
// Decode is the master; the sequencer is the slave.
interface pc_sequencer_if #(
  parameter int PC_W = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_mode;
  logic            req_cond_en;
  logic            req_cond;
  logic            req_likely;
  logic [15:0]     req_imm16;
  logic [25:0]     req_index26;
  logic [PC_W-1:0] req_reg;

  modport master (
    output req_valid,
    output req_mode,
    output req_cond_en,
    output req_cond,
    output req_likely,
    output req_imm16,
    output req_index26,
    output req_reg,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mode,
    input  req_cond_en,
    input  req_cond,
    input  req_likely,
    input  req_imm16,
    input  req_index26,
    input  req_reg,
    output req_ready
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch/jump/jr target generator.
// Targets are relative to the delay-slot address pc_i.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [1:0]      mode_i,
  input  logic [15:0]     imm16_i,
  input  logic [25:0]     index26_i,
  input  logic [PC_W-1:0] reg_i,
  output logic [PC_W-1:0] target_o,
  output logic            misaligned_o
);

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] j_tgt;

  assign br_off = {{(PC_W-18){imm16_i[15]}}, imm16_i, 2'b00};

  if (PC_W > 28) begin : g_region
    assign j_tgt = {pc_i[PC_W-1:28], index26_i, 2'b00};
  end else begin : g_flat
    assign j_tgt = {index26_i, 2'b00};
  end

  always_comb begin
    target_o = pc_i + PC_W'(4);
    unique case (mode_i)
      MODE_BR: target_o = pc_i + br_off;
      MODE_J:  target_o = j_tgt;
      MODE_JR: target_o = reg_i;
      default: target_o = pc_i + PC_W'(4);
    endcase
  end

  assign misaligned_o = (mode_i == MODE_JR) & (|reg_i[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Registered next-PC sequencer; holds taken redirects across stalls.
// Build option: BRANCH_LIKELY_EN drives annul_o, otherwise tied 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  pc_sequencer_if.slave   req,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            redirect_o,
  output logic            pending_o,
  output logic            misalign_o,
  output logic            annul_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [PC_W-1:0] target;
  logic            tgt_mis;
  logic            accept;
  logic            taken;

  pc_target_calc #(.PC_W(PC_W)) u_calc (
    .pc_i         (pc_q),
    .mode_i       (req.req_mode),
    .imm16_i      (req.req_imm16),
    .index26_i    (req.req_index26),
    .reg_i        (req.req_reg),
    .target_o     (target),
    .misaligned_o (tgt_mis)
  );

  assign req.req_ready = (state_q == ST_IDLE);
  assign accept = req.req_valid & req.req_ready;
  assign taken  = accept & (req.req_mode != MODE_SEQ)
                & (~req.req_cond_en | req.req_cond);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (taken) begin
          misalign_d = tgt_mis;
          if (stall_i) begin
            tgt_d   = target;
            state_d = ST_PENDING;
          end else begin
            pc_d       = target;
            redirect_d = 1'b1;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      ST_PENDING: begin
        if (!stall_i) begin
          pc_d       = tgt_q;
          redirect_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC[PC_W-1:0];
      tgt_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef BRANCH_LIKELY_EN
  // A squashed likely branch waits out any stall before annulling.
  logic annul_q, annul_d;
  logic annul_pend_q, annul_pend_d;
  logic likely_hit;
  logic annul_any;

  assign likely_hit = accept & (req.req_mode == MODE_BR) & req.req_cond_en
                    & req.req_likely & ~req.req_cond;
  assign annul_any  = likely_hit | annul_pend_q;

  always_comb begin
    annul_d      = annul_any & ~stall_i;
    annul_pend_d = annul_any & stall_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      annul_q      <= 1'b0;
      annul_pend_q <= 1'b0;
    end else begin
      annul_q      <= annul_d;
      annul_pend_q <= annul_pend_d;
    end
  end

  assign annul_o = annul_q;
`else
  logic unused_likely;
  assign unused_likely = req.req_likely;
  assign annul_o       = 1'b0;
`endif

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_W'(4);
  assign redirect_o = redirect_q;
  assign pending_o  = (state_q == ST_PENDING);
  assign misalign_o = misalign_q;

endmodule
